inc_arbiter: RTL
================

Name: inc_arbiter

Overview:
- Sequencer and arbiter for a shared increment counter, the datapath behind the team's inc_test counter instances.
- Collects increment requests from N_REQ requesters by detecting rising edges on their request levels.
- Queues requests per requester in saturating pending counters and grants them round-robin.
- Drives one clean single-cycle inc_pulse per grant while owning the counter value. All request sampling and counter updates are on clk, with no secondary edge-triggered processes.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- CNT_W, 2, shared counter width; wraps modulo 2^CNT_W.
- PEND_W, 2, per-requester pending counter width; PEND_MAX = 2^PEND_W-1.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request levels; each 0->1 transition is one increment event.
- hold  in  1  while 1, no new grants are issued; events are still queued.
- clr  in  1  synchronous clear of count and ovf.
- count  out  CNT_W  shared counter value.
- inc_pulse  out  1  high for exactly the ISSUE cycle.
- grant_id  out  $clog2(N_REQ) (min 1)  requester served in the current/last ISSUE.
- ack  out  N_REQ  one-hot, high during ISSUE for the granted requester.
- ovf  out  N_REQ  sticky; event dropped because that requester's pending counter was full.

Behaviour:
- Reset (async, rst=1):
  - count=0, inc_pulse=0, ack=0, ovf=0, grant_id=0.
  - All pending=0, req_q=0, state=IDLE, last_grant=N_REQ-1, so requester 0 has first priority.
  - Outputs go to these values immediately, not at the next edge.
- Edge detect:
  - rise[i] = req[i] & ~req_q[i], evaluated at each posedge; req_q <= req.
  - req high at reset release counts as one event.
- Pending update per requester, per edge:
  - pending += rise - svc, where svc = 1 when this edge enters ISSUE for i.
  - If rise, no svc, and pending==PEND_MAX: event dropped, ovf[i] <= 1.
  - If rise and svc in the same edge: pending unchanged, no ovf even if full.
- FSM states: IDLE, ISSUE, GAP (enum in package).
  - IDLE: if !hold and any pending != 0, go to ISSUE; else stay in IDLE.
  - ISSUE: always go to GAP after one cycle.
  - GAP: if !hold and any pending != 0, go to ISSUE; else go to IDLE.
- Selection:
  - Combinational from registered pending values.
  - Round-robin: first nonzero index searching from last_grant+1 upward, wrapping.
- On the edge entering ISSUE with winner g:
  - grant_id <= g, last_grant <= g, pending[g] decrements.
  - count <= count+1 (wraps at 2^CNT_W).
  - ISSUE-cycle outputs: inc_pulse=1, ack[g]=1.
- Outputs outside ISSUE: inc_pulse=0, ack=0; grant_id holds its last value.
- Latency: a rise sampled at edge E0 gives ISSUE (inc_pulse, ack, new count) in the cycle after E1.
- Throughput: maximum one grant per 2 cycles (ISSUE/GAP alternation); inc_pulse is never high on consecutive cycles.
- hold asserted:
  - During ISSUE, the current ISSUE completes.
  - From GAP it goes to IDLE; no further ISSUE until hold=0.
- clr:
  - count <= 0 and ovf <= 0.
  - clr on the same edge as ISSUE entry: count <= 1, grant proceeds normally.
  - clr does not affect pending or the FSM.
- Reset mid-ISSUE: pulse and ack drop at once; queued events are lost; no pulse after release unless req toggles again. A req level still high at release counts as one new event.

Decomposition:
- Package inc_arb_pkg:
  - state typedef (IDLE, ISSUE, GAP).
  - Default widths.
  - Function rr_pick(pending_nz, last_grant) returning index and valid.
- Sub-module inc_req_slot, instantiated N_REQ times:
  - Contains req_q, edge detect, saturating pending counter and sticky ovf.
  - Inputs: svc, clr.
  - Outputs: pending_nz, ovf.
- Top level contains the FSM, arbitration, count, grant_id and ack.

Test Plan:
- Reset: rst=1 with req=2'b11 -> count=0, inc_pulse=0, ack=0, ovf=0. Release with req still high -> exactly one grant each to 0 then 1, count=2.
- Single event: req[0] 0->1 sampled at edge E0 -> ack=2'b01 and inc_pulse=1 in the cycle after E1, count 0->1, pulse width exactly 1 cycle.
- Simultaneous: req 2'b00->2'b11 at E0 -> ISSUE for 0 (after E1), then for 1 (after E3), count=2, pulses 2 cycles apart.
- Alternating stimulus: req[0] toggled high/low every posedge for 8 rises -> 8 inc_pulses, count wraps 0->...->3->0, ovf=0. This directly checks that no increments are lost.
- Overflow: hold=1, 4 rises on req[0] -> ovf[0]=1, pending saturated at 3. hold=0 -> exactly 3 pulses, count=3. clr -> count=0, ovf=0.
- Reset mid-operation: queue 3 events on req[1]; assert rst during the first ISSUE -> inc_pulse and ack drop immediately, count=0. After release with req[1]=0 -> no pulses for 20 cycles.

Source files
------------

// File: rtl/inc_arb_pkg.sv
// ============================================================================
// Module : inc_arb_pkg
// Brief  : Shared types, default widths and round-robin helper for inc_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inc_arb_pkg;

    localparam int MAX_REQ    = 8;
    localparam int DEF_N_REQ  = 2;
    localparam int DEF_CNT_W  = 2;
    localparam int DEF_PEND_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First set bit of nz searching upward from last+1, wrapping within n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] nz,
                                      input logic [2:0]         last,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            j = (int'(last) + k) % n;
            if (k <= n && !p.valid && nz[j]) begin
                p.valid = 1'b1;
                p.idx   = 3'(j);
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inc_arbiter_if.sv
// ============================================================================
// Module : inc_arbiter_if
// Brief  : Request/status bundle between requesters and inc_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inc_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 2
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic             hold;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic             inc_pulse;
    logic [GID_W-1:0] grant_id;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] ovf;

    modport master (
        output req, hold, clr,
        input  count, inc_pulse, grant_id, ack, ovf
    );

    modport slave (
        input  req, hold, clr,
        output count, inc_pulse, grant_id, ack, ovf
    );

endinterface

`default_nettype wire

// File: rtl/inc_req_slot.sv
// ============================================================================
// Module : inc_req_slot
// Brief  : Per-requester edge detect, saturating pending counter, sticky ovf.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inc_req_slot #(
    parameter int PEND_W = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req,
    input  wire logic i_svc,
    input  wire logic i_clr,
    output logic      o_pending_nz,
    output logic      o_ovf
);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

    logic              r_req_q;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              w_rise;
    logic              w_drop;

    assign w_rise = i_req & ~r_req_q;
    assign w_drop = w_rise & ~i_svc & (r_pend == c_PEND_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q <= 1'b0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_req_q <= i_req;
            if (w_rise && !i_svc && !w_drop) begin
                r_pend <= r_pend + 1'b1;
            end else if (!w_rise && i_svc) begin
                r_pend <= r_pend - 1'b1;
            end
            if (i_clr) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_pending_nz = (r_pend != '0);
    assign o_ovf        = r_ovf;

endmodule

`default_nettype wire

// File: rtl/inc_arbiter.sv
// ============================================================================
// Module : inc_arbiter
// Brief  : Round-robin sequencer driving single-cycle increments of a shared counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inc_arbiter
    import inc_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    inc_arbiter_if.slave  bus
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   w_pend_nz;
    logic [N_REQ-1:0]   w_ovf;
    logic [N_REQ-1:0]   w_svc;
    logic [MAX_REQ-1:0] w_nz_ext;
    pick_t              w_pick;
    logic [GID_W-1:0]   w_win;
    logic               w_enter;

    state_t             r_state;
    logic [GID_W-1:0]   r_last;
    logic [GID_W-1:0]   r_gid;
    logic [CNT_W-1:0]   r_count;
    logic               r_pulse;
    logic [N_REQ-1:0]   r_ack;

    always_comb begin
        w_nz_ext              = '0;
        w_nz_ext[N_REQ-1:0]   = w_pend_nz;
    end

    assign w_pick  = rr_pick(w_nz_ext, 3'(r_last), N_REQ);
    assign w_win   = GID_W'(w_pick.idx);
    // ISSUE is always followed by GAP, which caps throughput at one grant per two cycles.
    assign w_enter = (r_state != ISSUE) && !bus.hold && w_pick.valid;

    always_comb begin
        w_svc = '0;
        if (w_enter) begin
            w_svc[w_win] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        inc_req_slot #(
            .PEND_W (PEND_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_req        (bus.req[gi]),
            .i_svc        (w_svc[gi]),
            .i_clr        (bus.clr),
            .o_pending_nz (w_pend_nz[gi]),
            .o_ovf        (w_ovf[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= GID_W'(N_REQ - 1);
            r_gid   <= '0;
            r_count <= '0;
            r_pulse <= 1'b0;
            r_ack   <= '0;
        end else begin
            case (r_state)
                ISSUE:   r_state <= GAP;
                default: r_state <= w_enter ? ISSUE : IDLE;
            endcase
            r_pulse <= w_enter;
            r_ack   <= w_svc;
            if (w_enter) begin
                r_gid   <= w_win;
                r_last  <= w_win;
                r_count <= bus.clr ? CNT_W'(1) : r_count + 1'b1;
            end else if (bus.clr) begin
                r_count <= '0;
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.inc_pulse = r_pulse;
    assign bus.grant_id  = r_gid;
    assign bus.ack       = r_ack;
    assign bus.ovf       = w_ovf;

endmodule

`default_nettype wire
